// File: rtl/classifier_pkg.sv
// Shared types and width helpers for the Haar classifier datapath.
package classifier_pkg;

  localparam int CORNERS_PER_RECT = 4;

  typedef enum logic [1:0] {IDLE, CORNERS, EMIT} state_t;

  typedef enum logic [$clog2(CORNERS_PER_RECT)-1:0] {P1, P2, P3, P4} corner_t;

  function automatic int acc_width(input int w_data, input int w_weight, input int max_rects);
    return w_data + 2 + w_weight + $clog2(max_rects);
  endfunction

endpackage

// File: rtl/rect_corner_sum.sv
// Four-corner rect summer: P1 - P2 + P3 - P4 over successive accepted samples.
// done strobes on the P4 sample; sum_next carries the finished rect sum in that cycle.
module rect_corner_sum
  import classifier_pkg::*;
#(
  parameter int W_DATA = 18
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     en,
  input  logic [W_DATA-1:0]        din,
  output logic signed [W_DATA+1:0] sum_next,
  output logic                     done
);

  localparam int W_CNT = $clog2(CORNERS_PER_RECT);

  corner_t                  corner;
  logic [W_CNT-1:0]         corner_inc;
  logic signed [W_DATA+1:0] rect_sum;
  logic signed [W_DATA+1:0] din_ext;

  assign din_ext    = {2'b00, din};
  assign corner_inc = corner + W_CNT'(1);
  assign done       = en && (corner == P4);

  always_comb begin
    sum_next = din_ext;
    case (corner)
      P1:      sum_next = din_ext;
      P2, P4:  sum_next = rect_sum - din_ext;
      P3:      sum_next = rect_sum + din_ext;
      default: sum_next = din_ext;
    endcase
  end

  // Corner counter wraps P4 -> P1 so consecutive rects need no explicit restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corner   <= P1;
      rect_sum <= '0;
    end else if (clear) begin
      corner   <= P1;
      rect_sum <= '0;
    end else if (en) begin
      corner   <= corner_t'(corner_inc);
      rect_sum <= sum_next;
    end
  end

endmodule

// File: rtl/feature_eval.sv
// Weighted Haar-feature evaluator: sum over rects of weight[k] * (P1 - P2 + P3 - P4).
// Define FEATURE_EVAL_THRESH_EN to add feat_thresh and the registered sum_pass flag.
module feature_eval
  import classifier_pkg::*;
#(
  parameter int  W_DATA    = 18,
  parameter int  W_WEIGHT  = 8,
  parameter int  MAX_RECTS = 3,
  localparam int W_NR      = $clog2(MAX_RECTS + 1),
  localparam int W_ACC     = acc_width(W_DATA, W_WEIGHT, MAX_RECTS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            feat_valid,
  output logic                            feat_ready,
  input  logic [W_NR-1:0]                 feat_nrects,
  input  logic [MAX_RECTS*W_WEIGHT-1:0]   feat_weights,
`ifdef FEATURE_EVAL_THRESH_EN
  input  logic signed [W_ACC-1:0]         feat_thresh,
  output logic                            sum_pass,
`endif
  input  logic                            din_valid,
  output logic                            din_ready,
  input  logic [W_DATA-1:0]               din_data,
  output logic                            sum_valid,
  input  logic                            sum_ready,
  output logic signed [W_ACC-1:0]         sum_data
);

  state_t                          state;
  logic [W_NR-1:0]                 nrects_q;
  logic [W_NR-1:0]                 rect;
  logic [MAX_RECTS*W_WEIGHT-1:0]   weights_q;
  logic signed [W_ACC-1:0]         acc;

  logic                            feat_fire;
  logic                            din_fire;
  logic                            rect_done;
  logic                            last_rect;
  logic [W_NR-1:0]                 nrects_clamped;
  logic signed [W_DATA+1:0]        rect_sum_next;
  logic signed [W_WEIGHT-1:0]      weight_cur;
  logic signed [W_ACC-1:0]         rect_sum_ext;
  logic signed [W_ACC-1:0]         weight_ext;
  logic signed [W_ACC-1:0]         acc_next;

  assign feat_fire      = feat_valid && feat_ready;
  assign din_fire       = din_valid && din_ready;
  assign nrects_clamped = (feat_nrects > W_NR'(MAX_RECTS)) ? W_NR'(MAX_RECTS) : feat_nrects;
  assign last_rect      = (rect == nrects_q - W_NR'(1));

  rect_corner_sum #(
    .W_DATA (W_DATA)
  ) u_rect_corner_sum (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (feat_fire),
    .en       (din_fire),
    .din      (din_data),
    .sum_next (rect_sum_next),
    .done     (rect_done)
  );

  always_comb begin
    weight_cur = '0;
    for (int k = 0; k < MAX_RECTS; k++) begin
      if (rect == W_NR'(k)) weight_cur = weights_q[k*W_WEIGHT +: W_WEIGHT];
    end
  end

  // W_ACC covers the largest possible product sum, so truncating the product never wraps.
  assign rect_sum_ext = {{(W_ACC-W_DATA-2){rect_sum_next[W_DATA+1]}}, rect_sum_next};
  assign weight_ext   = {{(W_ACC-W_WEIGHT){weight_cur[W_WEIGHT-1]}}, weight_cur};
  assign acc_next     = acc + rect_sum_ext * weight_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      feat_ready <= 1'b1;
      din_ready  <= 1'b0;
      sum_valid  <= 1'b0;
      sum_data   <= '0;
      nrects_q   <= '0;
      weights_q  <= '0;
      rect       <= '0;
      acc        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (feat_fire) begin
            nrects_q   <= nrects_clamped;
            weights_q  <= feat_weights;
            rect       <= '0;
            acc        <= '0;
            feat_ready <= 1'b0;
            if (nrects_clamped == '0) begin
              state     <= EMIT;
              sum_valid <= 1'b1;
              sum_data  <= '0;
            end else begin
              state     <= CORNERS;
              din_ready <= 1'b1;
            end
          end
        end
        CORNERS: begin
          if (rect_done) begin
            acc  <= acc_next;
            rect <= rect + W_NR'(1);
            if (last_rect) begin
              state     <= EMIT;
              din_ready <= 1'b0;
              sum_valid <= 1'b1;
              sum_data  <= acc_next;
            end
          end
        end
        EMIT: begin
          if (sum_ready) begin
            state      <= IDLE;
            sum_valid  <= 1'b0;
            feat_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FEATURE_EVAL_THRESH_EN
  localparam logic signed [W_ACC-1:0] ACC_ZERO = '0;

  logic signed [W_ACC-1:0] thresh_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thresh_q <= '0;
      sum_pass <= 1'b0;
    end else if (state == IDLE && feat_fire) begin
      thresh_q <= feat_thresh;
      if (nrects_clamped == '0) sum_pass <= (ACC_ZERO >= feat_thresh);
    end else if (state == CORNERS && rect_done && last_rect) begin
      sum_pass <= (acc_next >= thresh_q);
    end
  end
`endif

endmodule

// File: tb/tb_feature_eval.sv
// Scoreboard bench for feature_eval: a driver pushes model results, a monitor pops them on sum handshakes.
module tb_feature_eval;
  import classifier_pkg::*;

  localparam int W_DATA    = 18;
  localparam int W_WEIGHT  = 8;
  localparam int MAX_RECTS = 3;
  localparam int W_NR      = 2;
  localparam int W_ACC     = acc_width(W_DATA, W_WEIGHT, MAX_RECTS);
  localparam int MAX_VAL   = (1 << W_DATA) - 1;

  typedef struct {
    longint sum;
    bit     pass;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   hold_cnt = 0;
  bit   prev_fire = 0;
  bit   prev_hold = 0;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic                          feat_valid;
  logic                          feat_ready;
  logic [W_NR-1:0]               feat_nrects;
  logic [MAX_RECTS*W_WEIGHT-1:0] feat_weights;
  logic                          din_valid;
  logic                          din_ready;
  logic [W_DATA-1:0]             din_data;
  logic                          sum_valid;
  logic                          sum_ready;
  logic signed [W_ACC-1:0]       sum_data;
`ifdef FEATURE_EVAL_THRESH_EN
  logic signed [W_ACC-1:0]       feat_thresh;
  logic                          sum_pass;
`endif

  feature_eval #(
    .W_DATA    (W_DATA),
    .W_WEIGHT  (W_WEIGHT),
    .MAX_RECTS (MAX_RECTS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .feat_valid   (feat_valid),
    .feat_ready   (feat_ready),
    .feat_nrects  (feat_nrects),
    .feat_weights (feat_weights),
`ifdef FEATURE_EVAL_THRESH_EN
    .feat_thresh  (feat_thresh),
    .sum_pass     (sum_pass),
`endif
    .din_valid    (din_valid),
    .din_ready    (din_ready),
    .din_data     (din_data),
    .sum_valid    (sum_valid),
    .sum_ready    (sum_ready),
    .sum_data     (sum_data)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Called right after a negedge; ready is registered, so the value seen now holds through the next posedge.
  task automatic wait_ready(input bit is_din, output bit ok);
    bit r;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      r = is_din ? din_ready : feat_ready;
      @(negedge clk);
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_handshake: got no ready within 200 cycles, expected ready", is_din ? "din" : "feat");
    end
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk);
  endtask

  task automatic apply_stimulus(input int nr, input logic signed [7:0] w[3], input int c[12],
                                input longint thr, input int stop_after, input bit expect_out);
    longint s;
    exp_t   e;
    bit     ok;
    s = 0;
    for (int r = 0; r < nr; r++)
      s += longint'(w[r]) * (longint'(c[4*r]) - longint'(c[4*r+1]) + longint'(c[4*r+2]) - longint'(c[4*r+3]));
    e.sum  = s;
    e.pass = (s >= thr);
    if (expect_out) exp_q.push_back(e);

    feat_nrects  = W_NR'(nr);
    feat_weights = {w[2], w[1], w[0]};
`ifdef FEATURE_EVAL_THRESH_EN
    feat_thresh  = W_ACC'(thr);
`endif
    if (nr == 0) begin
      din_valid = 1'b1;
      din_data  = W_DATA'($urandom);
    end
    feat_valid = 1'b1;
    wait_ready(1'b0, ok);
    feat_valid = 1'b0;
    if (!ok) return;

    if (nr == 0) begin
      if (expect_out) check_output("latency_empty", sum_valid, 1);
      repeat (3) begin
        check_output("din_ignored", din_ready, 0);
        din_data = W_DATA'($urandom);
        @(negedge clk);
      end
      din_valid = 1'b0;
      return;
    end

    for (int i = 0; i < 4*nr; i++) begin
      if (stop_after >= 0 && i >= stop_after) return;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      din_data  = W_DATA'(c[i]);
      din_valid = 1'b1;
      wait_ready(1'b1, ok);
      din_valid = 1'b0;
      if (!ok) return;
    end
    if (expect_out) check_output("latency", sum_valid, 1);
  endtask

  // Monitor: drives sum_ready and compares every presented result against the queue head.
  always @(negedge clk) begin
    if (!rst_n) begin
      sum_ready = 1'b0;
      prev_fire = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (prev_fire) begin
        check_output("feat_ready_after_sum", feat_ready, 1);
        check_output("sum_valid_after_sum", sum_valid, 0);
      end
      if (prev_hold) check_output("sum_valid_held", sum_valid, 1);
      prev_fire = 1'b0;
      prev_hold = 1'b0;
      if (sum_valid) begin
        check_output("busy_readies", {feat_ready, din_ready}, 0);
        if (hold_cnt > 0) begin
          sum_ready = 1'b0;
          hold_cnt--;
        end else begin
          sum_ready = ($urandom_range(0, 3) != 0);
        end
        if (exp_q.size() == 0) begin
          check_output("unexpected_sum_queue", exp_q.size(), 1);
        end else begin
          check_output("sum_data", sum_data, exp_q[0].sum);
`ifdef FEATURE_EVAL_THRESH_EN
          check_output("sum_pass", sum_pass, exp_q[0].pass);
`endif
          if (sum_ready) void'(exp_q.pop_front());
        end
        prev_fire = sum_ready;
        prev_hold = !sum_ready;
      end else begin
        sum_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    int                c[12];
    logic signed [7:0] w[3];
    longint            thr;
    int                nr;

    rst_n        = 1'b1;
    feat_valid   = 1'b0;
    feat_nrects  = '0;
    feat_weights = '0;
    din_valid    = 1'b0;
    din_data     = '0;
`ifdef FEATURE_EVAL_THRESH_EN
    feat_thresh  = '0;
`endif
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_feat_ready", feat_ready, 1);
    check_output("reset_din_ready", din_ready, 0);
    check_output("reset_sum_valid", sum_valid, 0);
    check_output("reset_sum_data", sum_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    w = '{8'sd1, 8'sd0, 8'sd0};
    c = '{100, 40, 30, 10, 0, 0, 0, 0, 0, 0, 0, 0};
    apply_stimulus(1, w, c, 80, -1, 1'b1);
    apply_stimulus(1, w, c, 81, -1, 1'b1);

    w = '{8'sd3, -8'sd1, 8'sd0};
    c = '{50, 10, 5, 1, 20, 5, 2, 1, 0, 0, 0, 0};
    apply_stimulus(2, w, c, 116, -1, 1'b1);

    w = '{8'h80, 8'h80, 8'h80};
    c = '{MAX_VAL, 0, 0, 0, MAX_VAL, 0, 0, 0, MAX_VAL, 0, 0, 0};
    apply_stimulus(3, w, c, -100662912, -1, 1'b1);

    wait_drain();
    hold_cnt = 10;
    w = '{8'sd1, 8'sd0, 8'sd0};
    c = '{100, 40, 30, 10, 0, 0, 0, 0, 0, 0, 0, 0};
    apply_stimulus(1, w, c, 0, -1, 1'b1);
    w = '{8'sd3, -8'sd1, 8'sd0};
    c = '{50, 10, 5, 1, 20, 5, 2, 1, 0, 0, 0, 0};
    apply_stimulus(2, w, c, 200, -1, 1'b1);

    apply_stimulus(0, w, c, 0, -1, 1'b1);
    apply_stimulus(0, w, c, 1, -1, 1'b1);

    wait_drain();
    apply_stimulus(2, w, c, 0, 6, 1'b0);
    rst_n = 1'b0;
    #1;
    check_output("midreset_feat_ready", feat_ready, 1);
    check_output("midreset_din_ready", din_ready, 0);
    check_output("midreset_sum_valid", sum_valid, 0);
    check_output("midreset_sum_data", sum_data, 0);
`ifdef FEATURE_EVAL_THRESH_EN
    check_output("midreset_sum_pass", sum_pass, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_output("post_reset_sum_valid", sum_valid, 0);
    end
    w = '{8'sd1, 8'sd0, 8'sd0};
    c = '{100, 40, 30, 10, 0, 0, 0, 0, 0, 0, 0, 0};
    apply_stimulus(1, w, c, 80, -1, 1'b1);

    for (int t = 0; t < 40; t++) begin
      nr = $urandom_range(0, MAX_RECTS);
      for (int k = 0; k < 3; k++) w[k] = 8'($urandom);
      for (int i = 0; i < 12; i++) c[i] = $urandom_range(0, MAX_VAL);
      thr = longint'($signed($urandom)) >>> 3;
      apply_stimulus(nr, w, c, thr, -1, 1'b1);
    end

    wait_drain();
    check_output("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
